// File: rtl/ram_sp_param.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ram_sp_param: single-port RAM with byte enables, selectable read-during-write,
// optional output register and a post-reset clear sequencer.    Revision: 1.0
// -----------------------------------------------------------------------------
module ram_sp_param #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 8,
  parameter int                RDW_MODE       = 0,
  parameter int                OUT_REG        = 0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     din_i,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     dout_o,
  output logic                  dout_valid_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   dout_q;
  logic                valid_q;

  logic                w_acc;
  logic                w_ret;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   rdata_d;

  assign w_acc   = en_i && ready_q && !rst;
  // Writes only produce a return in write-first and read-first modes.
  assign w_ret   = w_acc && (!we_i || (RDW_MODE != 0));
  assign w_old   = mem_q[addr_i];
  assign rdata_d = (we_i && (RDW_MODE == 1)) ? w_merged : w_old;

  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < NB; b++) begin
      if (be_i[b]) w_merged[8*b +: 8] = din_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
      ready_q <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_CLEAR)) begin
      mem_q[cnt_q] <= CLEAR_VAL;
    end else if (w_acc && we_i) begin
      mem_q[addr_i] <= w_merged;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
          valid_q    <= 1'b0;
          dout_q     <= '0;
        end else begin
          s1_valid_q <= w_ret;
          if (w_ret) s1_data_q <= rdata_d;
          valid_q <= s1_valid_q;
          if (s1_valid_q) dout_q <= s1_data_q;
        end
      end
    end else begin : g_out_direct
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          dout_q  <= '0;
        end else begin
          valid_q <= w_ret;
          if (w_ret) dout_q <= rdata_d;
        end
      end
    end
  endgenerate

  assign ready_o      = ready_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;

endmodule
`default_nettype wire

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the team's fixed 16x256 single-port RAM, adding the following:
- generic width and depth
- per-byte write enables
- a selectable read-during-write mode
- an optional output register stage
- a valid-qualified read return
- a post-reset hardware clear sequencer, with a ready flag that blocks requests until the clear completes

It sits between register-file or buffer control logic and storage, as a drop-in scratch/data memory.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8.
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
RDW_MODE, 0, read-during-write behaviour: 0 = no-change, 1 = write-first, 2 = read-first.
OUT_REG, 0, 1 adds a second output pipeline stage (read latency becomes 2).
CLEAR_ON_RESET, 1, 1 = fill every word with CLEAR_VAL after reset; 0 = contents are untouched by reset.
CLEAR_VAL, 0, DATA_W-bit value written during clear.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst  input  1  synchronous, active-high reset.
en  input  1  request valid; a request is accepted on a cycle where en && ready.
we  input  1  1 = write, 0 = read; sampled with en.
addr  input  ADDR_W  word address.
be  input  DATA_W/8  byte enables for writes; bit i selects din[8i+7:8i]; ignored on reads.
din  input  DATA_W  write data.
ready  output  1  high when requests are accepted; low while clearing.
dout  output  DATA_W  read data; holds its last value when dout_valid is low.
dout_valid  output  1  one-cycle pulse qualifying dout.

Behaviour:
Clock and reset:
- One clock (clk); synchronous active-high reset (rst), sampled on the rising edge of clk.

Reset values:
- dout = 0, dout_valid = 0, all pipeline valids = 0, clear counter = 0.
- ready = 0 if CLEAR_ON_RESET = 1, else ready = 1 from the first cycle after rst deasserts.

State machine, states CLEAR and RUN:
- Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise RUN.
- In CLEAR, each cycle writes mem[cnt] = CLEAR_VAL and increments cnt.
- The cycle that writes cnt = DEPTH-1 transitions to RUN.
- ready rises on the next cycle, exactly DEPTH cycles after rst deasserts.
- RUN has no exit except rst.

Request handling:
- en while ready = 0: ignored; no memory write and no dout_valid.
- Accepted read: dout = mem[addr]. dout_valid pulses 1 cycle after acceptance (OUT_REG = 0) or 2 cycles after (OUT_REG = 1).
- The pipeline is fully pipelined: one request per cycle, returns in request order.
- Accepted write: for every i with be[i] = 1, byte i of mem[addr] takes din byte i; other bytes keep their old value.
- A write with be = 0 changes no memory but still follows the read-during-write mode below.

Read-during-write, i.e. data returned on an accepted write:
- RDW_MODE 0: dout unchanged, dout_valid stays 0.
- RDW_MODE 1: dout = merged new word (new bytes where be = 1, old bytes elsewhere), dout_valid pulses.
- RDW_MODE 2: dout = old word, dout_valid pulses.
- In modes 1 and 2 the return latency is the same as for a read.

Ordering:
- A read in the cycle after a write to the same address returns the written data (no stale-read hazard).

Reset mid-operation:
- In-flight returns are cancelled; no dout_valid after rst.
- Reset during CLEAR restarts the clear from address 0.
- With CLEAR_ON_RESET = 0, memory contents survive reset.

Addressing:
- The address covers exactly DEPTH words; there is no out-of-range case.

Test Plan:
1. Post-reset clear: defaults, 1-cycle rst pulse -> ready low for exactly 256 cycles, then high; reads of addresses 0..255 all return 0x0000 with dout_valid 1 cycle after each request.
2. Byte enables: write 0xFFFF to 0x10 with be = 2'b11, then write 0xABCD with be = 2'b01, then read 0x10 -> dout = 0xFFCD.
3. Read-during-write: preload mem[5] = 0x1234, then write 0x5678 to 5 with be = 2'b11.
   - Mode 0 -> dout keeps its previous value, no valid.
   - Mode 1 -> dout = 0x5678 with valid.
   - Mode 2 -> dout = 0x1234 with valid.
   - A following read of 5 returns 0x5678 in all modes.
4. OUT_REG = 1 streaming: after writing i+1 to addresses 0..3, issue back-to-back reads of 0..3 from cycle t -> dout_valid high on cycles t+2..t+5 with dout = 1, 2, 3, 4.
5. Reset mid-clear: assert rst when the clear counter = 100 -> clear restarts from address 0; ready rises 256 cycles after rst deasserts; all words read 0.
6. Requests while busy: during CLEAR, issue en = 1, we = 1, addr = 3, din = 0xBEEF -> ignored; after ready, reading 3 returns 0x0000 and no dout_valid appears during CLEAR.
